// File: rtl/rom_fetch_pkg.sv
// Shared constants for the ROM fetch cache: word width, default geometry and FSM state encodings.
package rom_fetch_pkg;

    localparam int ROM_WORD_W = 32;
    localparam int AW_DEF     = 25;
    localparam int IDX_W_DEF  = 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_ROM_REQ  = 3'd2;
    localparam logic [2:0] ST_ROM_WAIT = 3'd3;
    localparam logic [2:0] ST_FILL     = 3'd4;
    localparam logic [2:0] ST_PF_REQ   = 3'd5;
    localparam logic [2:0] ST_PF_WAIT  = 3'd6;

endpackage

// File: rtl/rom_fetch_cache_if.sv
// Bus bundle between the CPU fetch port / SPI ROM reader (master side) and rom_fetch_cache (slave side).
interface rom_fetch_cache_if
    import rom_fetch_pkg::*;
#(
    parameter int AW = AW_DEF
);

    // valid/ready: a transfer happens on a clk edge where both are high; the sender keeps valid
    // and its payload stable until that edge. resp_valid and rom_data_valid carry no back-pressure.
    logic                  req_valid;
    logic                  req_ready;
    logic [AW-1:0]         req_addr;
    logic                  resp_valid;
    logic [ROM_WORD_W-1:0] resp_data;
    logic                  flush;
    logic [AW-1:0]         rom_addr;
    logic                  rom_addr_valid;
    logic                  rom_addr_ready;
    logic [ROM_WORD_W-1:0] rom_data;
    logic                  rom_data_valid;

    modport master (
        output req_valid, req_addr, flush, rom_addr_ready, rom_data, rom_data_valid,
        input  req_ready, resp_valid, resp_data, rom_addr, rom_addr_valid
    );

    modport slave (
        input  req_valid, req_addr, flush, rom_addr_ready, rom_data, rom_data_valid,
        output req_ready, resp_valid, resp_data, rom_addr, rom_addr_valid
    );

endinterface

// File: rtl/rom_fetch_line_store.sv
// Direct-mapped line arrays: valid/tag/data, one write port, one combinational read port, flush-all.
module rom_fetch_line_store
    import rom_fetch_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int TAG_W = 20
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [ROM_WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [ROM_WORD_W-1:0] rd_data
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [ROM_WORD_W-1:0] data_q [LINES];

    // Only the valid bits need a reset; tag/data are ignored until their line is marked valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/rom_fetch_cache.sv
// Instruction-fetch cache in front of the SPI ROM reader: 1-word lines, one outstanding request.
// Optional next-word prefetch after a miss fill is enabled by defining ROM_FETCH_PREFETCH_EN.
module rom_fetch_cache
    import rom_fetch_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    rom_fetch_cache_if.slave bus,
    output state_t           state_dbg
);

    localparam int WA_W  = AW - 2;
    localparam int TAG_W = WA_W - IDX_W;

    // Addresses are held as word addresses so +1 wraps modulo 2**AW bytes for free.
    state_t                state_q, state_d;
    logic [WA_W-1:0]       addr_q, addr_d;
    logic [WA_W-1:0]       rom_wa_q, rom_wa_d;
    logic [ROM_WORD_W-1:0] data_q, data_d;
    logic [ROM_WORD_W-1:0] resp_data_q, resp_data_d;
    logic                  ready_q;
    logic                  resp_valid_q, resp_valid_d;
    logic                  rom_addr_valid_q, rom_addr_valid_d;
    logic                  flush_pending_q, flush_pending_d;

    logic                  accept, busy, discard, hit, wr_en;
    logic [ROM_WORD_W-1:0] wr_data, rd_data;
    logic [WA_W-1:0]       lk_addr;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic                  unused_lsbs;

    assign unused_lsbs    = ^bus.req_addr[1:0];
    assign bus.req_ready  = ready_q & ~bus.flush;
    assign accept         = bus.req_valid & bus.req_ready;
    assign discard        = flush_pending_q | bus.flush;

`ifdef ROM_FETCH_PREFETCH_EN
    logic [WA_W-1:0] next_wa;
    assign next_wa = addr_q + WA_W'(1);
    // During FILL the read port probes the following word to decide on a prefetch.
    assign lk_addr = (state_q == ST_FILL) ? next_wa : addr_q;
    assign busy    = state_q inside {ST_ROM_REQ, ST_ROM_WAIT, ST_FILL, ST_PF_REQ, ST_PF_WAIT};
`else
    assign lk_addr = addr_q;
    assign busy    = state_q inside {ST_ROM_REQ, ST_ROM_WAIT, ST_FILL};
`endif

    assign hit = rd_valid && (rd_tag == lk_addr[WA_W-1:IDX_W]);

    rom_fetch_line_store #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (bus.flush),
        .wr_en    (wr_en),
        .wr_idx   (addr_q[IDX_W-1:0]),
        .wr_tag   (addr_q[WA_W-1:IDX_W]),
        .wr_data  (wr_data),
        .rd_idx   (lk_addr[IDX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        rom_wa_d         = rom_wa_q;
        rom_addr_valid_d = rom_addr_valid_q;
        data_d           = data_q;
        resp_valid_d     = 1'b0;
        resp_data_d      = resp_data_q;
        wr_en            = 1'b0;
        wr_data          = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr[AW-1:2];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = rd_data;
                    state_d      = ST_IDLE;
                end else begin
                    rom_wa_d         = addr_q;
                    rom_addr_valid_d = 1'b1;
                    state_d          = ST_ROM_REQ;
                end
            end
            ST_ROM_REQ: begin
                if (bus.rom_addr_ready) begin
                    rom_addr_valid_d = 1'b0;
                    state_d          = ST_ROM_WAIT;
                end
            end
            ST_ROM_WAIT: begin
                if (bus.rom_data_valid) begin
                    data_d  = bus.rom_data;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                wr_en        = ~discard;
                resp_valid_d = 1'b1;
                resp_data_d  = data_q;
                state_d      = ST_IDLE;
`ifdef ROM_FETCH_PREFETCH_EN
                if (!hit) begin
                    addr_d           = next_wa;
                    rom_wa_d         = next_wa;
                    rom_addr_valid_d = 1'b1;
                    state_d          = ST_PF_REQ;
                end
`endif
            end
`ifdef ROM_FETCH_PREFETCH_EN
            ST_PF_REQ: begin
                if (bus.rom_addr_ready) begin
                    rom_addr_valid_d = 1'b0;
                    state_d          = ST_PF_WAIT;
                end
            end
            ST_PF_WAIT: begin
                if (bus.rom_data_valid) begin
                    wr_en   = ~discard;
                    wr_data = bus.rom_data;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        flush_pending_d = (state_d == ST_IDLE) ? 1'b0 : (flush_pending_q | (bus.flush & busy));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            rom_wa_q         <= '0;
            data_q           <= '0;
            resp_data_q      <= '0;
            ready_q          <= 1'b0;
            resp_valid_q     <= 1'b0;
            rom_addr_valid_q <= 1'b0;
            flush_pending_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            rom_wa_q         <= rom_wa_d;
            data_q           <= data_d;
            resp_data_q      <= resp_data_d;
            ready_q          <= (state_d == ST_IDLE);
            resp_valid_q     <= resp_valid_d;
            rom_addr_valid_q <= rom_addr_valid_d;
            flush_pending_q  <= flush_pending_d;
        end
    end

    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.rom_addr       = {rom_wa_q, 2'b00};
    assign bus.rom_addr_valid = rom_addr_valid_q;
    assign state_dbg          = state_q;

endmodule
